cipher_session_sched: RTL
=========================

Name: cipher_session_sched

Overview:
Round-robin scheduler that shares one byte-stream keystream cipher between N_REQ requesters, one whole message (session) at a time. The cipher's keystream counter loads on new_message and then advances every cycle whether or not a byte is presented. The scheduler therefore buffers each complete message first, then pulses new_message with the session key and streams the bytes on consecutive cycles. Cipher results are registered and returned tagged with the requester id.

Parameters:
N_REQ, 4, number of requesters (≥2)
MAX_LEN, 16, maximum message length in bytes (buffer depth)
LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)
ID_W, $clog2(N_REQ), width of requester id (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  N_REQ  session request per requester; sampled only in IDLE
req_key  in  N_REQ*8  per-requester session key, slot i at [8i+:8]
req_len  in  N_REQ*LEN_W  per-requester message length in bytes
in_valid  in  N_REQ  plaintext byte valid
in_data  in  N_REQ*8  plaintext byte
in_ready  out  N_REQ  byte accepted this cycle; only the granted slot can be high
done  out  N_REQ  one-cycle pulse when the granted session completes
cph_new_message  out  1  to cipher new_message
cph_key  out  8  to cipher key
cph_valid_in  out  1  to cipher valid_in
cph_data_in  out  8  to cipher data_in
cph_data_out  in  8  from cipher data_out (combinational, same cycle)
cph_valid_out  in  1  from cipher valid_out
out_valid  out  1  result byte valid; no backpressure
out_data  out  8  result byte
out_id  out  ID_W  owning requester
out_last  out  1  final byte of the session
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, active-high): state IDLE; rr pointer 0; all pointers 0; every output 0, including cph_*. Reset mid-session aborts it with no done pulse. At integration the cipher's reset_n is tied to ~reset.
- IDLE: grant the first asserted req at or after the rr pointer, wrapping. Latch grant, key and len. A len above MAX_LEN is clamped to MAX_LEN. If the latched len is 0, pulse done[grant] next cycle, return to IDLE and drive no cipher activity. Otherwise go to FILL.
- Round-robin: the pointer becomes grant+1 mod N_REQ when a session ends, including zero-length sessions.
- FILL: in_ready[grant] = 1. Each in_valid&in_ready handshake writes buf[wr_ptr] and increments wr_ptr. Valid on other slots is ignored. On the handshake where wr_ptr == len-1, go to LOAD. Gaps in in_valid are allowed.
- LOAD (1 cycle): cph_new_message = 1, cph_key = latched key, cph_valid_in = 0. Go to STREAM.
- STREAM: cph_new_message = 0, cph_valid_in = 1 and cph_data_in = buf[rd_ptr] every cycle with no gaps; rd_ptr increments each cycle.
  - Byte k uses keystream counter key+k mod 256; wrap from 0xFF to 0x00 is natural and needs no special handling.
  - The cycle after rd_ptr == len-1, go to IDLE.
- Output register: each STREAM cycle, out_data, out_valid and out_id register cph_data_out, cph_valid_out and grant. out_last = (rd_ptr == len-1), registered. done[grant] pulses in the same cycle as out_last. out_valid is 0 at all other times.
- Latency: LOAD is 1 cycle after the final fill handshake. out byte k appears LOAD+2+k cycles after that handshake. A session of L bytes occupies L+2 cycles after FILL completes, plus 1 IDLE cycle before the next grant.
- req deasserting after grant is ignored; the session runs to completion.
- A new req arriving during a session waits for IDLE.
- Simultaneous reqs resolve by the rr pointer only.

Decomposition:
- Package cipher_sched_pkg holds:
  - state enum {IDLE, FILL, LOAD, STREAM}
  - CIPHER_W = 8
  - helper function for the rotate-priority index
- Sub-module rr_arbiter (N_REQ parameterized) takes req and the pointer and returns a one-hot grant plus a valid flag.
- Byte buffer and FSM stay in the top.

Test Plan:
- req[0], key 0x00, len 1, byte 0x00 → cph_new_message pulse, then out_data 0x52, out_id 0, out_last=1, done[0] pulse same cycle.
- req[1], key 0x00, len 2, bytes 0x00, 0x00 with an in_valid gap → outputs 0x52 then 0x09 on consecutive cycles, no gap.
- Key 0x10, len 1, byte 0xFF → out_data 0x83. Key 0xFF, len 2, bytes 0x00, 0x00 → 0x7d then 0x52 (counter wrap).
- req = 4'b1111 held, each len 1 → grants in order 0,1,2,3,0. Zero-length request on slot 2 → done[2] with no out_valid and no cph_new_message.
- len 20 with MAX_LEN 16 → exactly 16 bytes accepted and output, out_last on the 16th.
- Reset asserted mid-STREAM → next cycle all outputs 0, state IDLE, no done. A fresh session then gives correct values from a pointer of 0.

Source files
------------

// File: rtl/cipher_sched_pkg.sv
// Shared definitions for the cipher session scheduler.
//   state_e  : scheduler FSM states
//   CIPHER_W : width of the cipher byte path and key
//   rot_idx  : rotate-priority index helper used by the round-robin arbiter
package cipher_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        LOAD   = 2'd2,
        STREAM = 2'd3
    } state_e;

    localparam int CIPHER_W = 8;

    // Position 'off' in the priority order that starts at 'base', wrapping modulo n.
    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// priority pointer, wrapping around.
// Ports:
//   req_i         : request vector
//   ptr_i         : index holding highest priority
//   grant_oh_o    : one-hot grant
//   grant_id_o    : binary index of the grant
//   grant_valid_o : at least one request was asserted
module rr_arbiter
    import cipher_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             grant_valid_o
);

    // Scan from lowest to highest priority so the highest-priority hit is
    // the last assignment and therefore wins.
    always_comb begin
        int idx;
        idx           = 0;
        grant_oh_o    = '0;
        grant_id_o    = '0;
        grant_valid_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = rot_idx(int'(ptr_i), i, N_REQ);
            if (req_i[idx]) begin
                grant_oh_o      = '0;
                grant_oh_o[idx] = 1'b1;
                grant_id_o      = ID_W'(idx);
                grant_valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_session_sched.sv
// Shares one byte-stream keystream cipher between N_REQ requesters, one whole
// message at a time. A granted message is first buffered completely, then the
// cipher is loaded with the session key and the bytes are streamed back to
// back, because the cipher's keystream counter advances every cycle.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req/req_key/req_len   : per-requester session request, key, length
//   in_valid/in_data      : per-requester plaintext bytes
//   in_ready              : byte accepted (granted slot in FILL only)
//   done                  : one-cycle pulse at session completion
//   cph_*                 : cipher interface (data_out is combinational)
//   out_valid/out_data/out_id/out_last : registered, tagged result bytes
//   busy                  : scheduler not idle
module cipher_session_sched
    import cipher_sched_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*CIPHER_W-1:0] req_key,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    input  logic [N_REQ-1:0]          in_valid,
    input  logic [N_REQ*CIPHER_W-1:0] in_data,
    output logic [N_REQ-1:0]          in_ready,
    output logic [N_REQ-1:0]          done,
    output logic                      cph_new_message,
    output logic [CIPHER_W-1:0]       cph_key,
    output logic                      cph_valid_in,
    output logic [CIPHER_W-1:0]       cph_data_in,
    input  logic [CIPHER_W-1:0]       cph_data_out,
    input  logic                      cph_valid_out,
    output logic                      out_valid,
    output logic [CIPHER_W-1:0]       out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_last,
    output logic                      busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Per-slot views of the packed request buses
    logic [CIPHER_W-1:0] key_arr  [N_REQ];
    logic [LEN_W-1:0]    len_arr  [N_REQ];
    logic [CIPHER_W-1:0] data_arr [N_REQ];

    state_e              state_q;
    logic [ID_W-1:0]     grant_q;
    logic [CIPHER_W-1:0] key_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    wr_ptr_q;
    logic [LEN_W-1:0]    rd_ptr_q;
    logic [ID_W-1:0]     rr_ptr_q;

    logic                out_valid_q;
    logic [CIPHER_W-1:0] out_data_q;
    logic [ID_W-1:0]     out_id_q;
    logic                out_last_q;
    logic [N_REQ-1:0]    done_q;

    logic [CIPHER_W-1:0] buf_mem [MAX_LEN];
    logic [CIPHER_W-1:0] rd_data_q;
    logic [LEN_W-1:0]    rd_addr_d;

    logic [N_REQ-1:0]    arb_oh;
    logic [ID_W-1:0]     arb_id;
    logic                arb_valid;
    logic [LEN_W-1:0]    arb_len_raw;
    logic [LEN_W-1:0]    arb_len;

    logic                sel_valid;
    logic [CIPHER_W-1:0] sel_data;
    logic                fill_hs;
    logic [LEN_W-1:0]    len_m1;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slot
            assign key_arr[gi]  = req_key[gi*CIPHER_W +: CIPHER_W];
            assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
            assign data_arr[gi] = in_data[gi*CIPHER_W +: CIPHER_W];
            assign in_ready[gi] = (state_q == FILL) && (grant_q == ID_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i         (req),
        .ptr_i         (rr_ptr_q),
        .grant_oh_o    (arb_oh),
        .grant_id_o    (arb_id),
        .grant_valid_o (arb_valid)
    );

    assign arb_len_raw = len_arr[arb_id];
    assign arb_len     = (arb_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : arb_len_raw;

    assign sel_valid = in_valid[grant_q];
    assign sel_data  = data_arr[grant_q];
    assign fill_hs   = (state_q == FILL) && sel_valid;
    assign len_m1    = len_q - LEN_W'(1);

    // Registered-read buffer: LOAD prefetches byte 0, each STREAM cycle
    // prefetches the following byte so the cipher sees one byte per cycle.
    always_comb begin
        rd_addr_d = '0;
        if (state_q == STREAM && rd_ptr_q != len_m1) begin
            rd_addr_d = rd_ptr_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_hs) begin
            buf_mem[wr_ptr_q[AW-1:0]] <= sel_data;
        end
        rd_data_q <= buf_mem[rd_addr_d[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            key_q       <= '0;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            done_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            done_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q  <= arb_id;
                        key_q    <= key_arr[arb_id];
                        len_q    <= arb_len;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        if (arb_len == '0) begin
                            // Empty session: finish at once, never touch the cipher
                            done_q   <= arb_oh;
                            rr_ptr_q <= ID_W'(rot_idx(int'(arb_id), 1, N_REQ));
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (sel_valid) begin
                        wr_ptr_q <= wr_ptr_q + LEN_W'(1);
                        if (wr_ptr_q == len_m1) begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    out_valid_q <= cph_valid_out;
                    out_data_q  <= cph_data_out;
                    out_id_q    <= grant_q;
                    out_last_q  <= (rd_ptr_q == len_m1);
                    rd_ptr_q    <= rd_ptr_q + LEN_W'(1);
                    if (rd_ptr_q == len_m1) begin
                        done_q   <= N_REQ'(1) << grant_q;
                        rr_ptr_q <= ID_W'(rot_idx(int'(grant_q), 1, N_REQ));
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cph_new_message = (state_q == LOAD);
    assign cph_key         = (state_q == LOAD) ? key_q : '0;
    assign cph_valid_in    = (state_q == STREAM);
    assign cph_data_in     = (state_q == STREAM) ? rd_data_q : '0;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule
